softmax_grad_unit: RTL and testbench

Backward-path companion to the softmax stage: takes the 10-class probability vector it produces plus the ground-truth label, and computes the output-layer error vector (p − onehot(label)), optionally scaled by a learning-rate shift. It also reports the predicted class (argmax) and a correct flag. It sits between the softmax output register and the weight-update logic, and uses the same packed 16-bit word format on both sides.

---
 rtl/net_fixed_pkg.sv | 29 ++
 rtl/softmax_grad_unit_if.sv | 26 ++
 rtl/fxp_sat_sub.sv | 28 ++
 rtl/softmax_grad_unit.sv | 140 ++++++++++++++
 tb/tb_softmax_grad_unit.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/net_fixed_pkg.sv
// Shared fixed-point definitions for the softmax forward/backward stages:
// packed 16-bit word format, saturation limits and sequencing states.
package net_fixed_pkg;

  localparam int unsigned WORD_W      = 16;
  localparam int unsigned NUM_CLASSES = 10;
  localparam int unsigned VEC_W       = WORD_W * NUM_CLASSES;
  localparam int unsigned CNT_W       = 4;

  localparam logic signed [7:0] Q_ONE = 8'sh10;
  localparam int SAT_MAX = 127;
  localparam int SAT_MIN = -128;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  // Q3.4 payload lives in bits [11:4]; the outer nibbles carry nothing.
  function automatic logic signed [7:0] unpack_q(input logic [WORD_W-1:0] w);
    return $signed(w[11:4]);
  endfunction

  function automatic logic [WORD_W-1:0] pack_q(input logic signed [7:0] v);
    return {4'b0000, v, 4'b0000};
  endfunction

endpackage

// File: rtl/softmax_grad_unit_if.sv
// Probability-in / gradient-out bus of the softmax backward stage.
interface softmax_grad_unit_if;
  import net_fixed_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [VEC_W-1:0] probs;
  logic [CNT_W-1:0] label;
  logic [VEC_W-1:0] grad_out;
  logic [CNT_W-1:0] pred_class;
  logic             correct;
  logic             label_err;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_valid, probs, label, out_ready,
    input  in_ready, grad_out, pred_class, correct, label_err, out_valid
  );

  modport slave (
    input  in_valid, probs, label, out_ready,
    output in_ready, grad_out, pred_class, correct, label_err, out_valid
  );

endinterface

// File: rtl/fxp_sat_sub.sv
// Combinational Q3.4 subtract: a - b saturated to 8 bits, then an
// arithmetic right shift (rounds toward -inf) by LR_SHIFT.
module fxp_sat_sub
  import net_fixed_pkg::*;
#(
  parameter int unsigned LR_SHIFT = 0
) (
  input  logic signed [7:0] i_a,
  input  logic signed [7:0] i_b,
  output logic signed [7:0] o_diff_c
);

  logic signed [8:0] w_diff;
  logic signed [7:0] w_sat;

  always_comb begin
    w_diff = 9'(i_a) - 9'(i_b);
    if (w_diff > 9'(SAT_MAX)) begin
      w_sat = 8'(SAT_MAX);
    end else if (w_diff < 9'(SAT_MIN)) begin
      w_sat = 8'(SAT_MIN);
    end else begin
      w_sat = w_diff[7:0];
    end
    o_diff_c = w_sat >>> LR_SHIFT;
  end

endmodule

// File: rtl/softmax_grad_unit.sv
// Output-layer error vector (p - onehot(label)) >>> LR_SHIFT, one class per
// cycle, plus argmax prediction and correctness flag.
module softmax_grad_unit
  import net_fixed_pkg::*;
#(
  parameter int unsigned LR_SHIFT = 0
) (
  input logic          clk,
  input logic          rst,
  softmax_grad_unit_if.slave sg
);

  state_t r_state;
  state_t w_next_state;

  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_label;
  logic signed [7:0] r_v [NUM_CLASSES];
  logic signed [7:0] r_max;
  logic [CNT_W-1:0]  r_idx;

  logic              r_in_ready;
  logic              r_out_valid;
  logic [VEC_W-1:0]  r_grad;
  logic [CNT_W-1:0]  r_pred_class;
  logic              r_correct;
  logic              r_label_err;

  logic              w_accept;
  logic              w_last;
  logic signed [7:0] w_v;
  logic signed [7:0] w_sub;
  logic signed [7:0] w_g;
  logic [CNT_W-1:0]  w_idx_next;
  logic              w_label_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (sg.in_valid) begin
          w_accept     = 1'b1;
          w_next_state = SCAN;
        end
      end
      SCAN: begin
        if (r_count == CNT_W'(NUM_CLASSES - 1)) begin
          w_last       = 1'b1;
          w_next_state = DONE;
        end
      end
      DONE: begin
        if (sg.out_ready) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Current class value, its onehot term, and the running argmax.
  always_comb begin
    w_v        = r_v[r_count];
    w_sub      = (r_label == r_count) ? Q_ONE : 8'sd0;
    w_idx_next = (w_v > r_max) ? r_count : r_idx;
    w_label_ok = (r_label < CNT_W'(NUM_CLASSES));
  end

  fxp_sat_sub #(.LR_SHIFT(LR_SHIFT)) u_sat_sub (
    .i_a      (w_v),
    .i_b      (w_sub),
    .o_diff_c (w_g)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_grad       <= '0;
      r_pred_class <= '0;
      r_correct    <= 1'b0;
      r_label_err  <= 1'b0;
      r_count      <= '0;
      r_label      <= '0;
      r_max        <= '0;
      r_idx        <= '0;
      for (int k = 0; k < NUM_CLASSES; k++) begin
        r_v[k] <= '0;
      end
    end else begin
      r_in_ready  <= (w_next_state == IDLE);
      r_out_valid <= (w_next_state == DONE);
      if (w_accept) begin
        r_label <= sg.label;
        r_count <= '0;
        r_max   <= unpack_q(sg.probs[WORD_W-1:0]);
        r_idx   <= '0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
          r_v[k] <= unpack_q(sg.probs[k*WORD_W +: WORD_W]);
        end
      end
      if (r_state == SCAN) begin
        r_count <= r_count + CNT_W'(1);
        r_idx   <= w_idx_next;
        if (w_v > r_max) begin
          r_max <= w_v;
        end
        for (int k = 0; k < NUM_CLASSES; k++) begin
          if (r_count == CNT_W'(k)) begin
            r_grad[k*WORD_W +: WORD_W] <= pack_q(w_g);
          end
        end
      end
      // Last class resolves the final argmax in the same edge that enters DONE.
      if (w_last) begin
        r_pred_class <= w_idx_next;
        r_correct    <= w_label_ok && (w_idx_next == r_label);
        r_label_err  <= !w_label_ok;
      end
    end
  end

  assign sg.in_ready   = r_in_ready;
  assign sg.out_valid  = r_out_valid;
  assign sg.grad_out   = r_grad;
  assign sg.pred_class = r_pred_class;
  assign sg.correct    = r_correct;
  assign sg.label_err  = r_label_err;

endmodule

// File: tb/tb_softmax_grad_unit.sv
// Scoreboard bench for softmax_grad_unit: directed vectors on two instances
// (LR_SHIFT 0 and 2), expectations queued at issue, checked at output handshake.
module tb_softmax_grad_unit;
  import net_fixed_pkg::*;

  typedef struct {
    logic [VEC_W-1:0] g;
    logic [3:0]       pc;
    logic             c;
    logic             e;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errs   = 0;
  exp_t q0[$];
  exp_t q1[$];

  softmax_grad_unit_if b0();
  softmax_grad_unit_if b1();

  softmax_grad_unit #(.LR_SHIFT(0)) u_dut0 (.clk(clk), .rst(rst), .sg(b0));
  softmax_grad_unit #(.LR_SHIFT(2)) u_dut1 (.clk(clk), .rst(rst), .sg(b1));

  always #5 clk = ~clk;

  function automatic logic [VEC_W-1:0] wd(input int idx, input logic [15:0] w);
    logic [VEC_W-1:0] v;
    v = '0;
    v[idx*WORD_W +: WORD_W] = w;
    return v;
  endfunction

  task automatic chk(input string name, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp_out(input string tag, input exp_t e, input logic [VEC_W-1:0] g,
                         input logic [3:0] pc, input logic c, input logic le);
    chk({tag, " grad_out"},   g,                e.g);
    chk({tag, " pred_class"}, VEC_W'(pc),       VEC_W'(e.pc));
    chk({tag, " correct"},    VEC_W'(c),        VEC_W'(e.c));
    chk({tag, " label_err"},  VEC_W'(le),       VEC_W'(e.e));
  endtask

  // Monitor: pops one expectation per completed output handshake.
  always @(negedge clk) begin
    if (!rst && b0.out_valid && b0.out_ready) begin
      if (q0.size() == 0) begin
        n_checks++; n_errs++;
        $display("FAIL dut0 unexpected output: got out_valid=1 expected no result pending");
      end else begin
        cmp_out("dut0", q0.pop_front(), b0.grad_out, b0.pred_class, b0.correct, b0.label_err);
      end
    end
    if (!rst && b1.out_valid && b1.out_ready) begin
      if (q1.size() == 0) begin
        n_checks++; n_errs++;
        $display("FAIL dut1 unexpected output: got out_valid=1 expected no result pending");
      end else begin
        cmp_out("dut1", q1.pop_front(), b1.grad_out, b1.pred_class, b1.correct, b1.label_err);
      end
    end
  end

  task automatic accept(input int u, input logic [VEC_W-1:0] p, input logic [3:0] l);
    @(negedge clk);
    if (u == 0) begin b0.probs = p; b0.label = l; b0.in_valid = 1'b1; end
    else        begin b1.probs = p; b1.label = l; b1.in_valid = 1'b1; end
    @(posedge clk); #1;
    // Scramble inputs after acceptance; they must not affect the result.
    if (u == 0) begin b0.in_valid = 1'b0; b0.probs = '1; b0.label = 4'd0; end
    else        begin b1.in_valid = 1'b0; b1.probs = '1; b1.label = 4'd0; end
  endtask

  task automatic wait_valid(input int u, output int n);
    logic ov;
    n = 0;
    ov = 1'b0;
    while (!ov && n < 40) begin
      @(posedge clk); #1;
      n++;
      ov = (u == 0) ? b0.out_valid : b1.out_valid;
    end
  endtask

  task automatic run(input int u, input string name, input logic [VEC_W-1:0] p, input logic [3:0] l,
                     input logic [VEC_W-1:0] eg, input logic [3:0] epc, input logic ec, input logic ee);
    exp_t e;
    int   n;
    e.g = eg; e.pc = epc; e.c = ec; e.e = ee;
    if (u == 0) q0.push_back(e); else q1.push_back(e);
    accept(u, p, l);
    chk({name, " in_ready after accept"}, VEC_W'((u == 0) ? b0.in_ready : b1.in_ready), '0);
    wait_valid(u, n);
    chk({name, " latency"}, VEC_W'(n), VEC_W'(10));
    @(posedge clk); #1;
    chk({name, " out_valid after handshake"}, VEC_W'((u == 0) ? b0.out_valid : b1.out_valid), '0);
    chk({name, " in_ready after handshake"},  VEC_W'((u == 0) ? b0.in_ready : b1.in_ready), VEC_W'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n;
    logic saw_valid;
    b0.in_valid = 1'b0; b0.probs = '0; b0.label = '0; b0.out_ready = 1'b1;
    b1.in_valid = 1'b0; b1.probs = '0; b1.label = '0; b1.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset in_ready",   VEC_W'(b0.in_ready),   VEC_W'(1));
    chk("reset out_valid",  VEC_W'(b0.out_valid),  '0);
    chk("reset grad_out",   b0.grad_out,           '0);
    chk("reset pred_class", VEC_W'(b0.pred_class), '0);
    chk("reset correct",    VEC_W'(b0.correct),    '0);
    chk("reset label_err",  VEC_W'(b0.label_err),  '0);

    run(0, "onehot_match", wd(3, 16'h0100), 4'd3, '0, 4'd3, 1'b1, 1'b0);
    run(0, "wrong_pred", wd(0, 16'h0040) | wd(7, 16'h00C0), 4'd0,
        wd(0, 16'h0F40) | wd(7, 16'h00C0), 4'd7, 1'b0, 1'b0);
    run(0, "tie", wd(2, 16'h0080) | wd(5, 16'h0080), 4'd5,
        wd(2, 16'h0080) | wd(5, 16'h0F80), 4'd2, 1'b0, 1'b0);
    run(0, "sat_neg", wd(4, 16'h0800), 4'd4, wd(4, 16'h0800), 4'd0, 1'b0, 1'b0);
    run(1, "sat_shift2", wd(4, 16'h0800), 4'd4, wd(4, 16'h0E00), 4'd0, 1'b0, 1'b0);
    run(1, "shift2_floor", wd(2, 16'h0070) | wd(8, 16'h0050), 4'd2,
        wd(2, 16'h0FD0) | wd(8, 16'h0010), 4'd2, 1'b1, 1'b0);
    run(0, "illegal_label", wd(1, 16'hF35A) | wd(6, 16'h1F7F) | wd(9, 16'h0203), 4'd12,
        wd(1, 16'h0350) | wd(6, 16'h0F70) | wd(9, 16'h0200), 4'd1, 1'b0, 1'b1);

    // Backpressure: results held, second request ignored while DONE.
    b0.out_ready = 1'b0;
    e.g = wd(0, 16'h0F40) | wd(7, 16'h00C0); e.pc = 4'd7; e.c = 1'b0; e.e = 1'b0;
    q0.push_back(e);
    accept(0, wd(0, 16'h0040) | wd(7, 16'h00C0), 4'd0);
    wait_valid(0, n);
    chk("hold latency", VEC_W'(n), VEC_W'(10));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold out_valid",  VEC_W'(b0.out_valid),  VEC_W'(1));
      chk("hold in_ready",   VEC_W'(b0.in_ready),   '0);
      chk("hold grad_out",   b0.grad_out,           e.g);
      chk("hold pred_class", VEC_W'(b0.pred_class), VEC_W'(4'd7));
      if (i == 1) begin b0.probs = wd(9, 16'h0100); b0.label = 4'd9; b0.in_valid = 1'b1; end
      if (i == 3) b0.in_valid = 1'b0;
    end
    b0.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold release out_valid", VEC_W'(b0.out_valid), '0);
    chk("hold release in_ready",  VEC_W'(b0.in_ready),  VEC_W'(1));
    repeat (3) @(posedge clk);
    #1 chk("no stray accept in_ready", VEC_W'(b0.in_ready), VEC_W'(1));

    // Reset in the middle of SCAN discards the partial result.
    accept(0, wd(0, 16'h0040) | wd(1, 16'h0100), 4'd5);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midreset out_valid",  VEC_W'(b0.out_valid),  '0);
    chk("midreset in_ready",   VEC_W'(b0.in_ready),   VEC_W'(1));
    chk("midreset grad_out",   b0.grad_out,           '0);
    chk("midreset pred_class", VEC_W'(b0.pred_class), '0);
    saw_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (b0.out_valid) saw_valid = 1'b1;
    end
    chk("midreset no result", VEC_W'(saw_valid), '0);

    chk("dut0 queue drained", VEC_W'(q0.size()), '0);
    chk("dut1 queue drained", VEC_W'(q1.size()), '0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
